// File: rtl/l1_tlb_refill_ctrl.sv
// rtl/l1_tlb_refill_ctrl.sv - L1 TLB miss/refill controller
// One outstanding miss; refills from the L2 TLB on a same-cycle hit, otherwise via the PTW.
module l1_tlb_refill_ctrl #(
  parameter int TAG_W   = 34,
  parameter int ENTRIES = 8,
  localparam int WAY_W  = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  input  logic [TAG_W-1:0] io_req_bits_vpn,
  input  logic             io_req_bits_instr,
  input  logic             io_req_bits_store,
  input  logic             tlb_miss,
  input  logic             io_l2tlb_resp_valid,
  input  logic             io_ptw_req_ready,
  input  logic             io_ptw_resp_valid,
  input  logic             io_sfence_valid,
  input  logic [ENTRIES-1:0] entry_valid,
  output logic [1:0]       state,
  output logic [TAG_W-1:0] r_refill_tag,
  output logic             r_req_instruction,
  output logic             r_req_store,
  output logic             refill_en,
  output logic             refill_from_l2,
  output logic [WAY_W-1:0] refill_way,
  output logic [31:0]      miss_count
);

  typedef enum logic [1:0] {
    S_READY           = 2'd0,
    S_REQUEST         = 2'd1,
    S_WAIT            = 2'd2,
    S_WAIT_INVALIDATE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] rr_ptr;
  logic [WAY_W-1:0] free_way;
  logic             all_valid;
  logic             miss_req;
  logic             count_miss;

  assign state     = state_q;
  assign miss_req  = (state_q == S_READY) && io_req_valid && tlb_miss;
  assign all_valid = &entry_valid;

  // Scan downwards so the lowest-index free way wins.
  always_comb begin
    free_way = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid[i]) free_way = WAY_W'(i);
    end
  end

  assign refill_way = all_valid ? rr_ptr : free_way;

  always_comb begin
    state_d        = state_q;
    refill_en      = 1'b0;
    refill_from_l2 = 1'b0;
    count_miss     = 1'b0;
    case (state_q)
      S_READY: begin
        if (miss_req && !io_sfence_valid) begin
          if (io_l2tlb_resp_valid) begin
            refill_en      = 1'b1;
            refill_from_l2 = 1'b1;
          end else begin
            state_d    = S_REQUEST;
            count_miss = 1'b1;
          end
        end
      end
      S_REQUEST: begin
        if (io_sfence_valid)       state_d = S_READY;
        else if (io_ptw_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (io_ptw_resp_valid) begin
          state_d   = S_READY;
          refill_en = !io_sfence_valid;
        end else if (io_sfence_valid) begin
          state_d = S_WAIT_INVALIDATE;
        end
      end
      S_WAIT_INVALIDATE: begin
        // The in-flight walk used stale tables; drain its response without writing it.
        if (io_ptw_resp_valid) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
    if (reset) begin
      refill_en      = 1'b0;
      refill_from_l2 = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_READY;
      r_refill_tag      <= '0;
      r_req_instruction <= 1'b0;
      r_req_store       <= 1'b0;
      rr_ptr            <= '0;
      miss_count        <= '0;
    end else begin
      state_q <= state_d;
      if (miss_req) begin
        r_refill_tag      <= io_req_bits_vpn;
        r_req_instruction <= io_req_bits_instr;
        r_req_store       <= io_req_bits_store;
      end
      if (refill_en && all_valid) rr_ptr <= rr_ptr + WAY_W'(1);
      if (count_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_l1_tlb_refill_ctrl.sv
// tb/tb_l1_tlb_refill_ctrl.sv - directed self-checking bench for l1_tlb_refill_ctrl
module tb_l1_tlb_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic [33:0] io_req_bits_vpn;
  logic        io_req_bits_instr;
  logic        io_req_bits_store;
  logic        tlb_miss;
  logic        io_l2tlb_resp_valid;
  logic        io_ptw_req_ready;
  logic        io_ptw_resp_valid;
  logic        io_sfence_valid;
  logic [7:0]  entry_valid;
  logic [1:0]  state;
  logic [33:0] r_refill_tag;
  logic        r_req_instruction;
  logic        r_req_store;
  logic        refill_en;
  logic        refill_from_l2;
  logic [2:0]  refill_way;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  l1_tlb_refill_ctrl #(.TAG_W(34), .ENTRIES(8)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_bits_vpn(io_req_bits_vpn),
    .io_req_bits_instr(io_req_bits_instr), .io_req_bits_store(io_req_bits_store),
    .tlb_miss(tlb_miss), .io_l2tlb_resp_valid(io_l2tlb_resp_valid),
    .io_ptw_req_ready(io_ptw_req_ready), .io_ptw_resp_valid(io_ptw_resp_valid),
    .io_sfence_valid(io_sfence_valid), .entry_valid(entry_valid),
    .state(state), .r_refill_tag(r_refill_tag),
    .r_req_instruction(r_req_instruction), .r_req_store(r_req_store),
    .refill_en(refill_en), .refill_from_l2(refill_from_l2),
    .refill_way(refill_way), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic miss(input logic [33:0] vpn, input logic instr, input logic store);
    io_req_valid = 1'b1; tlb_miss = 1'b1; io_req_bits_vpn = vpn;
    io_req_bits_instr = instr; io_req_bits_store = store;
  endtask

  task automatic idle_req();
    io_req_valid = 1'b0; tlb_miss = 1'b0; io_l2tlb_resp_valid = 1'b0;
    io_req_bits_vpn = '0; io_req_bits_instr = 1'b0; io_req_bits_store = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle_req();
    io_ptw_req_ready = 1'b0; io_ptw_resp_valid = 1'b0; io_sfence_valid = 1'b0;
    entry_valid = 8'h00;

    // Reset: an L2-hit miss while reset is high must not write
    tick();
    miss(34'h1, 1'b1, 1'b1); io_l2tlb_resp_valid = 1'b1;
    #1 chk("rst_refill_en", refill_en, 0);
    tick();
    chk("rst_state", state, 0);
    chk("rst_tag", r_refill_tag, 0);
    chk("rst_instr", r_req_instruction, 0);
    chk("rst_store", r_req_store, 0);
    chk("rst_miss_count", miss_count, 0);
    idle_req(); reset = 1'b0;

    // 1: PTW miss round trip
    tick();
    miss(34'h1234, 1'b0, 1'b0);
    #1 chk("t1_state_ready", state, 0);
    chk("t1_no_refill", refill_en, 0);
    tick(); idle_req();
    chk("t1_state_req", state, 1);
    chk("t1_tag", r_refill_tag, 34'h1234);
    chk("t1_count", miss_count, 1);
    io_ptw_req_ready = 1'b1;
    tick(); io_ptw_req_ready = 1'b0;
    chk("t1_state_wait", state, 2);
    io_ptw_resp_valid = 1'b1;
    #1 chk("t1_refill_en", refill_en, 1);
    chk("t1_from_l2", refill_from_l2, 0);
    chk("t1_way", refill_way, 0);
    tick(); io_ptw_resp_valid = 1'b0;
    chk("t1_state_back", state, 0);
    chk("t1_count_hold", miss_count, 1);

    // 2: L2 hits with all ways valid walk the round-robin pointer
    entry_valid = 8'hFF;
    miss(34'h2_0000_0ABC, 1'b0, 1'b0); io_l2tlb_resp_valid = 1'b1;
    #1 chk("t2_refill_en", refill_en, 1);
    chk("t2_from_l2", refill_from_l2, 1);
    chk("t2_way0", refill_way, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("t2_way7", refill_way, 7);
    chk("t2_refill_en7", refill_en, 1);
    chk("t2_state", state, 0);
    tick();
    chk("t2_way_wrap", refill_way, 0);
    chk("t2_count", miss_count, 1);
    chk("t2_tag", r_refill_tag, 34'h2_0000_0ABC);
    idle_req();

    // 3: sfence during the walk suppresses the later response
    entry_valid = 8'h0F;
    miss(34'h3_FFFF_FFFF, 1'b1, 1'b0);
    #1 chk("t3_way4", refill_way, 4);
    tick(); idle_req();
    chk("t3_state_req", state, 1);
    chk("t3_tag", r_refill_tag, 34'h3_FFFF_FFFF);
    chk("t3_instr", r_req_instruction, 1);
    chk("t3_store", r_req_store, 0);
    chk("t3_count", miss_count, 2);
    io_ptw_req_ready = 1'b1;
    tick(); io_ptw_req_ready = 1'b0;
    chk("t3_state_wait", state, 2);
    io_sfence_valid = 1'b1;
    #1 chk("t3_no_refill_sf", refill_en, 0);
    tick();
    chk("t3_state_inv", state, 3);
    tick(); io_sfence_valid = 1'b0;
    chk("t3_state_inv2", state, 3);
    io_ptw_resp_valid = 1'b1;
    #1 chk("t3_no_refill_resp", refill_en, 0);
    tick(); io_ptw_resp_valid = 1'b0;
    chk("t3_state_back", state, 0);

    // 4: sfence collides with response, then with request accept
    miss(34'h55, 1'b0, 1'b1);
    tick(); idle_req();
    chk("t4_state_req", state, 1);
    chk("t4_store", r_req_store, 1);
    chk("t4_instr", r_req_instruction, 0);
    chk("t4_count", miss_count, 3);
    io_ptw_req_ready = 1'b1;
    tick(); io_ptw_req_ready = 1'b0;
    chk("t4_state_wait", state, 2);
    io_ptw_resp_valid = 1'b1; io_sfence_valid = 1'b1;
    #1 chk("t4_no_refill", refill_en, 0);
    tick(); io_ptw_resp_valid = 1'b0; io_sfence_valid = 1'b0;
    chk("t4_state_ready", state, 0);
    miss(34'h66, 1'b0, 1'b0);
    tick(); idle_req();
    chk("t4_count2", miss_count, 4);
    io_ptw_req_ready = 1'b1; io_sfence_valid = 1'b1;
    tick(); io_ptw_req_ready = 1'b0; io_sfence_valid = 1'b0;
    chk("t4_sf_over_ready", state, 0);

    // 5: victim hole at way 3; reset mid-walk abandons the miss
    entry_valid = 8'b1111_0111;
    #1 chk("t5_way3", refill_way, 3);
    miss(34'h777, 1'b1, 1'b1);
    tick(); idle_req();
    chk("t5_state_req", state, 1);
    io_ptw_req_ready = 1'b1;
    tick(); io_ptw_req_ready = 1'b0;
    chk("t5_state_wait", state, 2);
    reset = 1'b1; io_ptw_resp_valid = 1'b1;
    #1 chk("t5_rst_no_refill", refill_en, 0);
    tick(); reset = 1'b0; io_ptw_resp_valid = 1'b0;
    chk("t5_state", state, 0);
    chk("t5_tag", r_refill_tag, 0);
    chk("t5_instr", r_req_instruction, 0);
    chk("t5_store", r_req_store, 0);
    chk("t5_count", miss_count, 0);
    entry_valid = 8'hFF;
    #1 chk("t5_rr_cleared", refill_way, 0);
    io_ptw_resp_valid = 1'b1;
    #1 chk("t5_late_resp", refill_en, 0);
    tick(); io_ptw_resp_valid = 1'b0;
    chk("t5_state_after", state, 0);

    // 6: miss counter saturates
    force dut.miss_count = 32'hFFFF_FFFE;
    tick();
    release dut.miss_count;
    #1 chk("t6_preload", miss_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      miss(34'h100 + 34'(i), 1'b0, 1'b0);
      tick(); idle_req();
      chk("t6_state_req", state, 1);
      chk("t6_count_sat", miss_count, 32'hFFFF_FFFF);
      io_sfence_valid = 1'b1;
      tick(); io_sfence_valid = 1'b0;
      chk("t6_state_ready", state, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
